// File: rtl/emu_time_manager.sv
// Emulator time manager: grants the smallest requested timestep each cycle,
// accumulates emulated time and cycle counts, and sequences IDLE/RUN/STEP/HALT
// with an optional absolute stop time.

// Clamps one signed timestep request to zero when negative.
module emu_dt_clamp #(
    parameter int DT_WIDTH = 27
) (
    input  logic [DT_WIDTH-1:0] req,
    output logic [DT_WIDTH-1:0] clamped
);
    assign clamped = req[DT_WIDTH-1] ? '0 : req;
endmodule

module emu_time_manager #(
    parameter int                  N_REQ      = 4,
    parameter int                  DT_WIDTH   = 27,
    parameter int                  TIME_WIDTH = 64,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = {1'b0, {(DT_WIDTH-1){1'b1}}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic                      run_en,
    input  logic                      step_req,
    input  logic                      stop_en,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    input  logic                      halt_clr,
    output logic [DT_WIDTH-1:0]       dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [31:0]               emu_cycles,
    output logic                      halted,
    output logic                      running
);
    // Wide enough to compare the remaining time against DT_MAX without loss.
    localparam int CW = ((TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH) + 1;
    localparam int SW = TIME_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;
    state_t state;

    logic [N_REQ-1:0][DT_WIDTH-1:0] req_clamped;
    logic [DT_WIDTH-1:0]            dt_min;
    logic [DT_WIDTH-1:0]            rem;
    logic [TIME_WIDTH-1:0]          diff;
    logic [SW-1:0]                  sum_ext;
    logic                           active;
    logic                           stop_hit;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        emu_dt_clamp #(.DT_WIDTH(DT_WIDTH)) u_clamp (
            .req    (dt_req[i*DT_WIDTH +: DT_WIDTH]),
            .clamped(req_clamped[i])
        );
    end

    // Smallest non-negative request, bounded above by DT_MAX.
    always_comb begin
        dt_min = DT_MAX;
        for (int i = 0; i < N_REQ; i++)
            if (req_clamped[i] < dt_min) dt_min = req_clamped[i];
    end

    assign diff = stop_time - emu_time;

    // Time left before the stop point, saturated into the dt range.
    always_comb begin
        rem = DT_MAX;
        if (stop_time <= emu_time)
            rem = '0;
        else if (CW'(diff) <= CW'(DT_MAX))
            rem = DT_WIDTH'(diff);
    end

    assign active = (state == RUN) || (state == STEP);

    // Zero-latency grant so requesters can consume dt in the same cycle.
    always_comb begin
        dt = '0;
        if (active)
            dt = (stop_en && (rem < dt_min)) ? rem : dt_min;
    end

    // One extra bit keeps the stop comparison correct across the wrap point.
    assign sum_ext  = {1'b0, emu_time} + SW'(dt);
    assign stop_hit = stop_en && (sum_ext >= {1'b0, stop_time});

    assign halted  = (state == HALT);
    assign running = active;

    // Time/cycle accumulation and the run-control state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            emu_time   <= '0;
            emu_cycles <= '0;
        end else begin
            emu_time <= sum_ext[TIME_WIDTH-1:0];
            if (dt != '0) emu_cycles <= emu_cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (run_en)        state <= RUN;
                    else if (step_req) state <= STEP;
                end
                RUN: begin
                    if (stop_hit)     state <= HALT;
                    else if (!run_en) state <= IDLE;
                end
                STEP:    state <= stop_hit ? HALT : IDLE;
                HALT:    if (halt_clr) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_emu_time_manager.sv
// Directed scenarios plus randomized traffic against a behavioural model of
// the time manager. Emulated time is narrowed to 32 bits so the wrap boundary
// is reachable in a few dozen cycles; the arithmetic is width-independent.
module tb_emu_time_manager;
    localparam int    NR    = 4;
    localparam int    DW    = 27;
    localparam int    TW    = 32;
    localparam longint DTMAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint TMASK = (longint'(1) << TW) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic signed [DW-1:0]  req [NR];
    logic [NR*DW-1:0]      dt_req;
    logic                  run_en = 0, step_req = 0, stop_en = 0, halt_clr = 0;
    logic [TW-1:0]         stop_time = '0;
    logic [DW-1:0]         dt;
    logic [TW-1:0]         emu_time;
    logic [31:0]           emu_cycles;
    logic                  halted, running;

    int checks = 0;
    int failures = 0;

    // Model: 0 idle, 1 free-running, 2 single step, 3 halted.
    int     m_state;
    longint m_time;
    longint m_cycles;

    assign dt_req = {req[3], req[2], req[1], req[0]};

    emu_time_manager #(.N_REQ(NR), .DT_WIDTH(DW), .TIME_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .dt_req(dt_req), .run_en(run_en),
        .step_req(step_req), .stop_en(stop_en), .stop_time(stop_time),
        .halt_clr(halt_clr), .dt(dt), .emu_time(emu_time),
        .emu_cycles(emu_cycles), .halted(halted), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_dt();
        longint d, r, v;
        if (m_state != 1 && m_state != 2) return 0;
        d = DTMAX;
        for (int i = 0; i < NR; i++) begin
            v = longint'(req[i]);
            if (v < 0) v = 0;
            if (v < d) d = v;
        end
        if (stop_en) begin
            r = longint'(stop_time) - m_time;
            if (r < 0) r = 0;
            if (r > DTMAX) r = DTMAX;
            if (r < d) d = r;
        end
        return d;
    endfunction

    task automatic set_req(input int a, input int b, input int c, input int d);
        req[0] = DW'(a); req[1] = DW'(b); req[2] = DW'(c); req[3] = DW'(d);
    endtask

    // One clock cycle: compare outputs with the model, then advance both.
    task automatic cyc(input longint want_dt);
        longint d;
        bit hit;
        #1;
        d = model_dt();
        chk("dt", 64'(dt), 64'(d));
        if (want_dt >= 0) chk("dt_const", 64'(dt), 64'(want_dt));
        chk("halted", 64'(halted), 64'(m_state == 3));
        chk("running", 64'(running), 64'(m_state == 1 || m_state == 2));
        chk("emu_time", 64'(emu_time), 64'(m_time));
        chk("emu_cycles", 64'(emu_cycles), 64'(m_cycles));
        hit = stop_en && (m_time + d >= longint'(stop_time));
        case (m_state)
            0: m_state = run_en ? 1 : (step_req ? 2 : 0);
            1: m_state = hit ? 3 : (run_en ? 1 : 0);
            2: m_state = hit ? 3 : 0;
            default: m_state = halt_clr ? 0 : 3;
        endcase
        m_time = (m_time + d) & TMASK;
        if (d != 0) m_cycles = (m_cycles + 1) & 64'hFFFF_FFFF;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_emu_time", 64'(emu_time), 0);
        chk("rst_emu_cycles", 64'(emu_cycles), 0);
        chk("rst_dt", 64'(dt), 0);
        chk("rst_running", 64'(running), 0);
        chk("rst_halted", 64'(halted), 0);
        run_en = 0; step_req = 0; stop_en = 0; halt_clr = 0; stop_time = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0; m_time = 0; m_cycles = 0;
    endtask

    initial begin
        bit done;
        int v;
        set_req(0, 0, 0, 0);
        m_state = 0; m_time = 0; m_cycles = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Free run with a negative request: clamps to zero grant.
        set_req(100, 40, -5, 70);
        run_en = 1;
        cyc(0);
        for (int k = 0; k < 5; k++) cyc(0);
        chk("free_time", 64'(emu_time), 0);
        chk("free_cycles", 64'(emu_cycles), 0);
        chk("free_running", 64'(running), 1);

        // Minimum selection.
        do_reset();
        set_req(100, 40, 300, 70);
        run_en = 1;
        cyc(0);
        for (int k = 0; k < 10; k++) cyc(40);
        chk("min_time", 64'(emu_time), 400);
        chk("min_cycles", 64'(emu_cycles), 10);

        // Stop clamping into HALT, then clear.
        do_reset();
        set_req(40, 40, 40, 40);
        stop_en = 1; stop_time = 100; run_en = 1;
        cyc(0);
        cyc(40); cyc(40); cyc(20);
        run_en = 0;
        chk("stop_halted", 64'(halted), 1);
        cyc(0);
        chk("stop_time", 64'(emu_time), 100);
        halt_clr = 1;
        cyc(0);
        halt_clr = 0;
        chk("clr_halted", 64'(halted), 0);
        chk("clr_running", 64'(running), 0);

        // Single step, then step_req held high.
        do_reset();
        set_req(25, 25, 25, 25);
        step_req = 1;
        cyc(0);
        step_req = 0;
        chk("step_running", 64'(running), 1);
        cyc(25);
        chk("step_idle", 64'(running), 0);
        chk("step_time", 64'(emu_time), 25);
        step_req = 1;
        cyc(0); cyc(25); cyc(0); cyc(25);
        step_req = 0;
        chk("step_held_time", 64'(emu_time), 75);

        // Async reset during RUN discards accumulated time.
        do_reset();
        set_req(100, 100, 100, 100);
        run_en = 1;
        cyc(0);
        for (int k = 0; k < 10; k++) cyc(100);
        chk("pre_rst_time", 64'(emu_time), 1000);
        do_reset();

        // Wrap: reach 2^TW-10 via stop clamping, then add 40.
        set_req(int'(DTMAX), int'(DTMAX), int'(DTMAX), int'(DTMAX));
        stop_en = 1; stop_time = 32'hFFFF_FFF6; run_en = 1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            cyc(-1);
            done = (m_state == 3);
        end
        chk("wrap_halted", 64'(halted), 1);
        chk("wrap_pre_time", 64'(emu_time), 64'hFFFF_FFF6);
        run_en = 0; halt_clr = 1;
        cyc(0);
        halt_clr = 0; stop_en = 0;
        set_req(40, 40, 40, 40);
        run_en = 1;
        cyc(0);
        cyc(40);
        chk("wrap_time", 64'(emu_time), 30);
        run_en = 0;

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NR; i++) begin
                v = int'($urandom_range(0, 220)) - 20;
                req[i] = DW'(v);
            end
            run_en   = ($urandom_range(0, 3) != 0);
            step_req = $urandom_range(0, 1);
            halt_clr = ($urandom_range(0, 3) == 0);
            stop_en  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0 && m_time >= 5)
                stop_time = TW'(m_time - 5);
            else
                stop_time = TW'(m_time + longint'($urandom_range(0, 400)));
            cyc(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
